// File: rtl/rps_round_ctrl_pkg.sv
// Shared codes for the rock-paper-scissors round controller and its display/LED consumers.
package rps_round_ctrl_pkg;

    typedef enum logic [1:0] {
        CH_NONE     = 2'b00,
        CH_ROCK     = 2'b01,
        CH_PAPER    = 2'b10,
        CH_SCISSORS = 2'b11
    } choice_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_JUDGE = 3'd2,
        ST_SHOW  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

endpackage

// File: rtl/rps_round_ctrl_rise_detect.sv
// Two-flop sampler with a single-cycle rising-edge pulse.
// The first sample after reset primes both flops, so a level already high at reset never pulses.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic q1_q, q1_d;
    logic q2_q, q2_d;
    logic armed_q, armed_d;

    // Next-state for the sampling pipeline
    always_comb begin
        q1_d    = din;
        armed_d = 1'b1;
        if (armed_q) begin
            q2_d = q1_q;
        end else begin
            q2_d = din;
        end
    end

    // Sampling flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q    <= 1'b0;
            q2_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            armed_q <= armed_d;
        end
    end

    assign pulse = q1_q & ~q2_q;

endmodule

// File: rtl/rps_round_ctrl.sv
// Round controller: countdown on slow ticks, sample choices, judge, keep score, declare the match winner.
module rps_round_ctrl
    import rps_round_ctrl_pkg::*;
#(
    parameter int COUNT_SEC  = 3,
    parameter int SHOW_TICKS = 2,
    parameter int WIN_SCORE  = 3,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               slow_clk,
    input  logic               start,
    input  logic [1:0]         p1_choice,
    input  logic [1:0]         p2_choice,
    output logic [3:0]         countdown,
    output logic [1:0]         result,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam logic [3:0]         CD_LOAD   = 4'(COUNT_SEC);
    localparam logic [3:0]         HOLD_LOAD = 4'(SHOW_TICKS);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    logic tick_s;
    logic go_s;

    state_e             state_q,     state_d;
    logic [3:0]         countdown_q, countdown_d;
    logic [3:0]         hold_q,      hold_d;
    result_e            result_q,    result_d;
    logic [SCORE_W-1:0] score1_q,    score1_d;
    logic [SCORE_W-1:0] score2_q,    score2_d;
    logic               game_over_q, game_over_d;
    result_e            winner_q,    winner_d;
    choice_e            p1_lat_q,    p1_lat_d;
    choice_e            p2_lat_q,    p2_lat_d;

    logic [SCORE_W-1:0] score1_inc_s;
    logic [SCORE_W-1:0] score2_inc_s;
    result_e            verdict_s;

    rise_detect u_tick_det (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (slow_clk),
        .pulse (tick_s)
    );

    rise_detect u_go_det (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (start),
        .pulse (go_s)
    );

    // A missing choice forfeits; two missing choices are a draw like any other equal pair.
    function automatic result_e judge(input choice_e a, input choice_e b);
        result_e r;
        if (a == b) begin
            r = RES_DRAW;
        end else if (a == CH_NONE) begin
            r = RES_P2;
        end else if (b == CH_NONE) begin
            r = RES_P1;
        end else if ((a == CH_ROCK     && b == CH_SCISSORS) ||
                     (a == CH_SCISSORS && b == CH_PAPER)    ||
                     (a == CH_PAPER    && b == CH_ROCK)) begin
            r = RES_P1;
        end else begin
            r = RES_P2;
        end
        return r;
    endfunction

    assign score1_inc_s = score1_q + {{(SCORE_W-1){1'b0}}, 1'b1};
    assign score2_inc_s = score2_q + {{(SCORE_W-1){1'b0}}, 1'b1};
    assign verdict_s    = judge(p1_lat_q, p2_lat_q);

    // Round sequencing and scoring
    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        hold_d      = hold_q;
        result_d    = result_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        p1_lat_d    = p1_lat_q;
        p2_lat_d    = p2_lat_q;

        case (state_q)
            ST_IDLE: begin
                if (go_s) begin
                    countdown_d = CD_LOAD;
                    state_d     = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (tick_s) begin
                    if (countdown_q > 4'd1) begin
                        countdown_d = countdown_q - 4'd1;
                    end else begin
                        countdown_d = 4'd0;
                        p1_lat_d    = choice_e'(p1_choice);
                        p2_lat_d    = choice_e'(p2_choice);
                        state_d     = ST_JUDGE;
                    end
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_JUDGE: begin
                result_d = verdict_s;
                hold_d   = HOLD_LOAD;
                state_d  = ST_SHOW;
                if (verdict_s == RES_P1) begin
                    score1_d = score1_inc_s;
                    if (score1_inc_s == WIN_VAL) begin
                        game_over_d = 1'b1;
                        winner_d    = RES_P1;
                        state_d     = ST_OVER;
                    end else begin
                        state_d = ST_SHOW;
                    end
                end else if (verdict_s == RES_P2) begin
                    score2_d = score2_inc_s;
                    if (score2_inc_s == WIN_VAL) begin
                        game_over_d = 1'b1;
                        winner_d    = RES_P2;
                        state_d     = ST_OVER;
                    end else begin
                        state_d = ST_SHOW;
                    end
                end else begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (tick_s) begin
                    hold_d = hold_q - 4'd1;
                    if (hold_q <= 4'd1) begin
                        result_d    = RES_NONE;
                        countdown_d = CD_LOAD;
                        state_d     = ST_COUNT;
                    end else begin
                        state_d = ST_SHOW;
                    end
                end else begin
                    state_d = ST_SHOW;
                end
            end
            ST_OVER: begin
                if (go_s) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    result_d    = RES_NONE;
                    winner_d    = RES_NONE;
                    game_over_d = 1'b0;
                    countdown_d = CD_LOAD;
                    state_d     = ST_COUNT;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            countdown_q <= 4'd0;
            hold_q      <= 4'd0;
            result_q    <= RES_NONE;
            score1_q    <= '0;
            score2_q    <= '0;
            game_over_q <= 1'b0;
            winner_q    <= RES_NONE;
            p1_lat_q    <= CH_NONE;
            p2_lat_q    <= CH_NONE;
        end else begin
            state_q     <= state_d;
            countdown_q <= countdown_d;
            hold_q      <= hold_d;
            result_q    <= result_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            p1_lat_q    <= p1_lat_d;
            p2_lat_q    <= p2_lat_d;
        end
    end

    assign countdown = countdown_q;
    assign result    = result_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Directed bench for rps_round_ctrl: a game-rule model checked every cycle plus literal spot checks.
module tb_rps_round_ctrl;

    localparam int COUNT_SEC  = 3;
    localparam int SHOW_TICKS = 2;
    localparam int WIN_SCORE  = 3;
    localparam int SCORE_W    = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               slow_clk = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         p1_choice = 2'b00;
    logic [1:0]         p2_choice = 2'b00;
    logic [3:0]         countdown;
    logic [1:0]         result;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               game_over;
    logic [1:0]         winner;
    logic [2:0]         state;

    int checks = 0;
    int errors = 0;

    rps_round_ctrl #(
        .COUNT_SEC  (COUNT_SEC),
        .SHOW_TICKS (SHOW_TICKS),
        .WIN_SCORE  (WIN_SCORE),
        .SCORE_W    (SCORE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .slow_clk  (slow_clk),
        .start     (start),
        .p1_choice (p1_choice),
        .p2_choice (p2_choice),
        .countdown (countdown),
        .result    (result),
        .score1    (score1),
        .score2    (score2),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    // Phase numbers are the externally visible state codes.
    int m_phase = 0, m_cd = 0, m_hold = 0, m_res = 0;
    int m_s1 = 0, m_s2 = 0, m_over = 0, m_win = 0, m_l1 = 0, m_l2 = 0;
    int sc_new = 0, sc_old = 0, st_new = 0, st_old = 0, nsamp = 0;

    // Winner of one round: equal -> draw, a blank loses, else cyclic rock<paper<scissors<rock.
    function automatic int rule(input int a, input int b);
        if (a == b) return 3;
        if (a == 0) return 2;
        if (b == 0) return 1;
        return (((a - b + 3) % 3) == 1) ? 1 : 2;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_cd = 0; m_hold = 0; m_res = 0;
                m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0; m_l1 = 0; m_l2 = 0;
                sc_new = 0; sc_old = 0; st_new = 0; st_old = 0; nsamp = 0;
            end else begin
                // An edge is acted on once two real samples 0 then 1 exist since reset.
                automatic bit tick = (nsamp >= 2) && (sc_new == 1) && (sc_old == 0);
                automatic bit go   = (nsamp >= 2) && (st_new == 1) && (st_old == 0);
                sc_old = sc_new; sc_new = int'(slow_clk);
                st_old = st_new; st_new = int'(start);
                nsamp++;
                case (m_phase)
                    0: if (go) begin m_cd = COUNT_SEC; m_phase = 1; end
                    1: if (tick) begin
                           if (m_cd > 1) m_cd--;
                           else begin
                               m_cd = 0; m_l1 = int'(p1_choice); m_l2 = int'(p2_choice); m_phase = 2;
                           end
                       end
                    2: begin
                           m_res = rule(m_l1, m_l2);
                           if (m_res == 1) m_s1++;
                           if (m_res == 2) m_s2++;
                           if (m_s1 == WIN_SCORE) begin m_over = 1; m_win = 1; m_phase = 4; end
                           else if (m_s2 == WIN_SCORE) begin m_over = 1; m_win = 2; m_phase = 4; end
                           else begin m_hold = SHOW_TICKS; m_phase = 3; end
                       end
                    3: if (tick) begin
                           m_hold--;
                           if (m_hold == 0) begin m_res = 0; m_cd = COUNT_SEC; m_phase = 1; end
                       end
                    4: if (go) begin
                           m_s1 = 0; m_s2 = 0; m_res = 0; m_win = 0; m_over = 0;
                           m_cd = COUNT_SEC; m_phase = 1;
                       end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("state",     16'(state),     16'(m_phase));
        chk("countdown", 16'(countdown), 16'(m_cd));
        chk("result",    16'(result),    16'(m_res));
        chk("score1",    16'(score1),    16'(m_s1));
        chk("score2",    16'(score2),    16'(m_s2));
        chk("game_over", 16'(game_over), 16'(m_over));
        chk("winner",    16'(winner),    16'(m_win));
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic slow_period();
        #1 slow_clk = 1'b1;
        repeat (4) @(negedge clk);
        #1 slow_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        #1 start = 1'b1;
        repeat (2) @(negedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic play(input logic [1:0] c1, input logic [1:0] c2);
        p1_choice = c1;
        p2_choice = c2;
        repeat (COUNT_SEC) slow_period();
    endtask

    task automatic show_out();
        repeat (SHOW_TICKS) slow_period();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #29 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("lit_reset_state", 16'(state), 16'd0);
        chk("lit_reset_cd",    16'(countdown), 16'd0);

        pulse_start();
        chk("lit_go_state", 16'(state), 16'd1);
        chk("lit_go_cd",    16'(countdown), 16'd3);

        // Round 1: rock vs scissors
        play(2'b01, 2'b11);
        chk("lit_r1_result", 16'(result), 16'd1);
        chk("lit_r1_score1", 16'(score1), 16'd1);
        chk("lit_r1_state",  16'(state), 16'd3);
        pulse_start();
        show_out();
        chk("lit_r1_back_state", 16'(state), 16'd1);
        chk("lit_r1_back_cd",    16'(countdown), 16'd3);

        // Round 2: paper draw, with go pulsed mid-countdown
        p1_choice = 2'b10; p2_choice = 2'b10;
        slow_period();
        pulse_start();
        repeat (COUNT_SEC - 1) slow_period();
        chk("lit_r2_result", 16'(result), 16'd3);
        chk("lit_r2_score1", 16'(score1), 16'd1);
        chk("lit_r2_score2", 16'(score2), 16'd0);
        show_out();

        // Round 3: blank vs rock
        play(2'b00, 2'b01);
        chk("lit_r3_result", 16'(result), 16'd2);
        chk("lit_r3_score2", 16'(score2), 16'd1);
        show_out();

        // Rounds 4 and 5: P1 reaches the winning score
        play(2'b10, 2'b01);
        show_out();
        play(2'b11, 2'b10);
        chk("lit_over_state", 16'(state), 16'd4);
        chk("lit_over_flag",  16'(game_over), 16'd1);
        chk("lit_over_winner", 16'(winner), 16'd1);
        repeat (2) slow_period();
        chk("lit_over_hold_state",  16'(state), 16'd4);
        chk("lit_over_hold_score1", 16'(score1), 16'd3);

        pulse_start();
        chk("lit_restart_state",  16'(state), 16'd1);
        chk("lit_restart_cd",     16'(countdown), 16'd3);
        chk("lit_restart_score1", 16'(score1), 16'd0);
        chk("lit_restart_over",   16'(game_over), 16'd0);

        // Reset dropped during the judge cycle
        p1_choice = 2'b01; p2_choice = 2'b11;
        repeat (COUNT_SEC - 1) slow_period();
        #1 slow_clk = 1'b1;
        begin
            automatic bit found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(posedge clk);
                #1;
                if (m_phase == 2) found = 1'b1;
            end
            chk("judge_wait_found", 16'(found), 16'd1);
        end
        chk("lit_in_judge", 16'(state), 16'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_arst_state",  16'(state), 16'd0);
        chk("lit_arst_score1", 16'(score1), 16'd0);
        chk("lit_arst_result", 16'(result), 16'd0);
        chk("lit_arst_cd",     16'(countdown), 16'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("lit_post_rst_state", 16'(state), 16'd0);
        #1 slow_clk = 1'b0;
        repeat (3) @(negedge clk);

        // go coincident with tick in IDLE
        #1 start = 1'b1; slow_clk = 1'b1;
        repeat (2) @(negedge clk);
        chk("lit_cotick_state", 16'(state), 16'd1);
        chk("lit_cotick_cd",    16'(countdown), 16'd3);
        @(negedge clk);
        chk("lit_cotick_cd_hold", 16'(countdown), 16'd3);
        #1 start = 1'b0; slow_clk = 1'b0;
        repeat (3) @(negedge clk);

        // Clean round after recovery: scissors vs rock
        play(2'b11, 2'b01);
        chk("lit_rec_result", 16'(result), 16'd2);
        chk("lit_rec_score2", 16'(score2), 16'd1);
        show_out();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
